// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory fetch unit.
package imem_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        F_OK    = 2'b00,
        F_MISAL = 2'b01,
        F_RANGE = 2'b10
    } fault_e;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/imem_sram_1r1w.sv
// Word array with one synchronous write port and one combinational read port.
module imem_sram_1r1w
    import imem_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 64,
    localparam int IDX_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with valid/ready fetch port, loader write port, fault decode
// and a clear sweep that fills the array with CLR_VAL after every reset.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 64,
    parameter int              ADDR_W   = 32,
    parameter int              READ_LAT = 1,
    parameter logic [XLEN-1:0] CLR_VAL  = XLEN'(NOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [XLEN-1:0]   prog_data,
    output logic              prog_err,
    output logic              init_done
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Misalignment takes precedence over the range fault.
    function automatic fault_e decode_fault(input logic [ADDR_W-1:0] a);
        if (a[1:0] != 2'b00) return F_MISAL;
        if (a[ADDR_W-1:IDX_W+2] != '0) return F_RANGE;
        return F_OK;
    endfunction

    state_e           state;
    logic [CNT_W-1:0] clr_cnt;
    logic             clr_we;
    logic             prog_ok;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [XLEN-1:0]  mem_wdata;
    logic [XLEN-1:0]  rd_data;
    logic             stall;
    logic             accept;

    // Sweep writes indices 0..DEPTH-1; the extra count value marks the hand-over to RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else if (state == S_CLEAR) begin
            if (clr_cnt == CNT_W'(DEPTH)) begin
                state     <= S_RUN;
                init_done <= 1'b1;
            end else begin
                clr_cnt <= clr_cnt + CNT_W'(1);
            end
        end
    end

    assign clr_we    = (state == S_CLEAR) && !clr_cnt[IDX_W];
    assign prog_ok   = prog_we && (state == S_RUN) && (decode_fault(prog_addr) == F_OK);
    assign mem_we    = clr_we || prog_ok;
    assign mem_waddr = clr_we ? clr_cnt[IDX_W-1:0] : prog_addr[IDX_W+1:2];
    assign mem_wdata = clr_we ? CLR_VAL : prog_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prog_err <= 1'b0;
        else       prog_err <= prog_we && !prog_ok;
    end

    imem_sram_1r1w #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (fetch_addr[IDX_W+1:2]),
        .rdata (rd_data)
    );

    assign stall       = rsp_valid && !rsp_ready;
    assign fetch_ready = (state == S_RUN) && !prog_we && !stall;
    assign accept      = fetch_valid && fetch_ready;

    // Stage p0: accept cycle; the word is captured here so later writes cannot touch it.
    fault_e          fault_p0;
    logic [XLEN-1:0] instr_p0;

    assign fault_p0 = decode_fault(fetch_addr);
    assign instr_p0 = (fault_p0 == F_OK) ? rd_data : CLR_VAL;

    logic              vld_tail;
    logic [XLEN-1:0]   instr_tail;
    logic [ADDR_W-1:0] addr_tail;
    logic [1:0]        fault_tail;

    if (READ_LAT == 2) begin : g_lat2
        // Stage p1: extra register stage, frozen together with the output stage.
        logic              vld_p1;
        logic [XLEN-1:0]   instr_p1;
        logic [ADDR_W-1:0] addr_p1;
        logic [1:0]        fault_p1;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)       vld_p1 <= 1'b0;
            else if (!stall) vld_p1 <= accept;
        end

        always_ff @(posedge clk) begin
            if (!stall) begin
                instr_p1 <= instr_p0;
                addr_p1  <= fetch_addr;
                fault_p1 <= fault_p0;
            end
        end

        assign vld_tail   = vld_p1;
        assign instr_tail = instr_p1;
        assign addr_tail  = addr_p1;
        assign fault_tail = fault_p1;
    end else begin : g_lat1
        assign vld_tail   = accept;
        assign instr_tail = instr_p0;
        assign addr_tail  = fetch_addr;
        assign fault_tail = fault_p0;
    end

    // Output stage: holds while the consumer back-pressures.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_fault <= F_OK;
        end else if (!stall) begin
            rsp_valid <= vld_tail;
            rsp_instr <= instr_tail;
            rsp_addr  <= addr_tail;
            rsp_fault <= fault_tail;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: one instance per read latency, checked against a word-array model.
module tb_imem_fetch_unit;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        fetch_valid [2];
    logic        fetch_ready [2];
    logic [31:0] fetch_addr  [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [31:0] rsp_instr   [2];
    logic [31:0] rsp_addr    [2];
    logic [1:0]  rsp_fault   [2];
    logic        prog_we     [2];
    logic [31:0] prog_addr   [2];
    logic [31:0] prog_data   [2];
    logic        prog_err    [2];
    logic        init_done   [2];

    logic [31:0] mem_m [DEPTH];
    rsp_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    imem_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(1), .CLR_VAL(NOP)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid[0]), .fetch_ready(fetch_ready[0]), .fetch_addr(fetch_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
        .rsp_addr(rsp_addr[0]), .rsp_fault(rsp_fault[0]),
        .prog_we(prog_we[0]), .prog_addr(prog_addr[0]), .prog_data(prog_data[0]),
        .prog_err(prog_err[0]), .init_done(init_done[0])
    );

    imem_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(2), .CLR_VAL(NOP)) u_dut_lat2 (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid[1]), .fetch_ready(fetch_ready[1]), .fetch_addr(fetch_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
        .rsp_addr(rsp_addr[1]), .rsp_fault(rsp_fault[1]),
        .prog_we(prog_we[1]), .prog_addr(prog_addr[1]), .prog_data(prog_data[1]),
        .prog_err(prog_err[1]), .init_done(init_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic rsp_t model_rsp(input logic [31:0] a);
        rsp_t r;
        r.addr = a;
        if (a[1:0] != 2'b00) begin
            r.fault = 2'b01;
            r.instr = NOP;
        end else if ((a >> 2) >= DEPTH) begin
            r.fault = 2'b10;
            r.instr = NOP;
        end else begin
            r.fault = 2'b00;
            r.instr = mem_m[a >> 2];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (r == 7)      a = a | 32'($urandom_range(1, 3));
        else if (r == 8) a = a + 32'(DEPTH * 4);
        else if (r == 9) a = {1'b1, 29'($urandom), 2'b00};
        return a;
    endfunction

    task automatic drive(input int d, input bit fv, input logic [31:0] fa, input bit we,
                         input logic [31:0] wa, input logic [31:0] wd, input bit rr);
        fetch_valid[d] = fv;
        fetch_addr[d]  = fa;
        prog_we[d]     = we;
        prog_addr[d]   = wa;
        prog_data[d]   = wd;
        rsp_ready[d]   = rr;
    endtask

    // One clock of instance d: score the response, the handshake and the loader error pulse.
    task automatic tick(input int d, output bit acc, output bit popped);
        bit   legal;
        bit   err_exp;
        bit   exp_ready;
        rsp_t e;
        #1;
        popped = 1'b0;
        if (rsp_valid[d] === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_spurious: dut%0d got rsp_valid=1 addr=%h, required no response", d, rsp_addr[d]);
            end else begin
                e = exp_q[0];
                if ({rsp_instr[d], rsp_addr[d], rsp_fault[d]} !== {e.instr, e.addr, e.fault}) begin
                    n_fail++;
                    $display("FAIL rsp_data: dut%0d got instr=%h addr=%h fault=%b, required instr=%h addr=%h fault=%b",
                             d, rsp_instr[d], rsp_addr[d], rsp_fault[d], e.instr, e.addr, e.fault);
                end
                if (rsp_ready[d]) begin
                    void'(exp_q.pop_front());
                    popped = 1'b1;
                end
            end
        end
        exp_ready = !prog_we[d] && (rsp_ready[d] || rsp_valid[d] !== 1'b1);
        n_checks++;
        if (fetch_ready[d] !== exp_ready) begin
            n_fail++;
            $display("FAIL fetch_ready: dut%0d got %b, required %b", d, fetch_ready[d], exp_ready);
        end
        acc = fetch_valid[d] && (fetch_ready[d] === 1'b1);
        if (acc) exp_q.push_back(model_rsp(fetch_addr[d]));
        legal   = (prog_addr[d][1:0] == 2'b00) && ((prog_addr[d] >> 2) < DEPTH);
        err_exp = prog_we[d] && !legal;
        if (prog_we[d] && legal) mem_m[prog_addr[d] >> 2] = prog_data[d];
        @(posedge clk);
        #1;
        n_checks++;
        if (prog_err[d] !== err_exp) begin
            n_fail++;
            $display("FAIL prog_err: dut%0d got %b, required %b", d, prog_err[d], err_exp);
        end
    endtask

    task automatic drain(input int d);
        bit acc;
        bit pop;
        int k;
        drive(d, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            tick(d, acc, pop);
            k++;
        end
        tick(d, acc, pop);
        tick(d, acc, pop);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: dut%0d got %0d responses outstanding, required 0", d, exp_q.size());
        end
    endtask

    // Issue one fetch and wait until its response is on the outputs, checking the latency.
    task automatic fetch_one(input int d, input logic [31:0] a);
        bit acc;
        bit pop;
        int k;
        drive(d, 1'b1, a, 1'b0, 32'h0, 32'h0, 1'b1);
        tick(d, acc, pop);
        n_checks++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_accept: dut%0d addr=%h got accepted=%b, required 1", d, a, acc);
        end
        drive(d, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        k = 1;
        while (rsp_valid[d] !== 1'b1 && k < 10) begin
            tick(d, acc, pop);
            k++;
        end
        n_checks++;
        if (k != d + 1) begin
            n_fail++;
            $display("FAIL latency: dut%0d got %0d cycles, required %0d", d, k, d + 1);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({fetch_ready[k], rsp_valid[k], rsp_instr[k], rsp_addr[k], rsp_fault[k], prog_err[k], init_done[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_values: dut%0d got rdy=%b vld=%b instr=%h addr=%h fault=%b err=%b done=%b, required all zero",
                         k, fetch_ready[k], rsp_valid[k], rsp_instr[k], rsp_addr[k], rsp_fault[k], prog_err[k], init_done[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (init_done[0] !== 1'b1 && n < 300) begin
            for (int k = 0; k < 2; k++)
                drive(k, 1'b0, 32'h0, n == DEPTH - 2, 32'h0, 32'hDEADBEEF, 1'b1);
            @(posedge clk);
            #1;
            n++;
            if (n == DEPTH - 1) begin
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (prog_err[k] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL prog_err_clear: dut%0d got %b, required 1", k, prog_err[k]);
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        n_checks++;
        if (n != DEPTH + 1 || init_done[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_timing: got %0d cycles (dut1 done=%b), required %0d", n, init_done[1], DEPTH + 1);
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
        exp_q.delete();
    endtask

    task automatic test_idle_fetch(input int d);
        fetch_one(d, 32'h0);
        n_checks++;
        if (rsp_instr[d] !== NOP || rsp_fault[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_fetch: dut%0d got instr=%h fault=%b, required %h 00", d, rsp_instr[d], rsp_fault[d], NOP);
        end
        drain(d);
    endtask

    task automatic test_program(input int d);
        bit acc;
        bit pop;
        drive(d, 1'b0, 32'h0, 1'b1, 32'h2C, 32'h00948663, 1'b1);
        tick(d, acc, pop);
        fetch_one(d, 32'h2C);
        n_checks++;
        if (rsp_instr[d] !== 32'h00948663 || rsp_addr[d] !== 32'h2C) begin
            n_fail++;
            $display("FAIL program_read: dut%0d got instr=%h addr=%h, required 00948663 0000002c", d, rsp_instr[d], rsp_addr[d]);
        end
        drain(d);
    endtask

    task automatic test_faults(input int d);
        bit acc;
        bit pop;
        fetch_one(d, 32'h2E);
        n_checks++;
        if (rsp_fault[d] !== 2'b01 || rsp_instr[d] !== NOP) begin
            n_fail++;
            $display("FAIL misaligned: dut%0d got fault=%b instr=%h, required 01 %h", d, rsp_fault[d], rsp_instr[d], NOP);
        end
        drain(d);
        fetch_one(d, 32'h100);
        n_checks++;
        if (rsp_fault[d] !== 2'b10 || rsp_instr[d] !== NOP) begin
            n_fail++;
            $display("FAIL out_of_range: dut%0d got fault=%b instr=%h, required 10 %h", d, rsp_fault[d], rsp_instr[d], NOP);
        end
        drain(d);
        drive(d, 1'b0, 32'h0, 1'b1, 32'h101, 32'hCAFEF00D, 1'b1);
        tick(d, acc, pop);
        drive(d, 1'b0, 32'h0, 1'b1, 32'h100, 32'hCAFEF00D, 1'b1);
        tick(d, acc, pop);
        fetch_one(d, 32'h0);
        n_checks++;
        if (rsp_instr[d] !== NOP) begin
            n_fail++;
            $display("FAIL bad_write_dropped: dut%0d got instr=%h, required %h", d, rsp_instr[d], NOP);
        end
        drain(d);
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] addrs [3];
        bit          acc;
        bit          pop;
        bit          rr;
        int          idx;
        int          pops;
        int          stalls;
        int          c;
        addrs[0] = 32'h4;
        addrs[1] = 32'h8;
        addrs[2] = 32'hC;
        idx = 0; pops = 0; stalls = 0; c = 0;
        while ((idx < 3 || exp_q.size() != 0) && c < 30) begin
            rr = !(c >= 2 && c <= 4);
            drive(d, idx < 3, addrs[idx < 3 ? idx : 2], 1'b0, 32'h0, 32'h0, rr);
            if (rsp_valid[d] === 1'b1 && !rr) stalls++;
            tick(d, acc, pop);
            if (acc) idx++;
            if (pop) pops++;
            c++;
        end
        n_checks++;
        if (pops != 3 || stalls != 3) begin
            n_fail++;
            $display("FAIL back_to_back: dut%0d got %0d responses %0d stall cycles, required 3 and 3", d, pops, stalls);
        end
        drain(d);
    endtask

    task automatic test_prog_priority(input int d);
        logic [31:0] wd;
        bit          acc;
        bit          pop;
        wd = $urandom | 32'h80000000;
        drive(d, 1'b1, 32'h30, 1'b1, 32'h30, wd, 1'b1);
        tick(d, acc, pop);
        n_checks++;
        if (acc !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_priority: dut%0d got fetch accepted=%b, required 0", d, acc);
        end
        fetch_one(d, 32'h30);
        n_checks++;
        if (rsp_instr[d] !== wd) begin
            n_fail++;
            $display("FAIL retry_read: dut%0d got instr=%h, required %h", d, rsp_instr[d], wd);
        end
        drain(d);
    endtask

    task automatic test_random(input int d);
        bit acc;
        bit pop;
        int n_acc;
        n_acc = 0;
        for (int i = 0; i < 300; i++) begin
            drive(d, $urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 7) == 0,
                  rand_addr(), $urandom, $urandom_range(0, 3) != 0);
            tick(d, acc, pop);
            if (acc) n_acc++;
        end
        drain(d);
        n_checks++;
        if (n_acc < 50) begin
            n_fail++;
            $display("FAIL random_progress: dut%0d got %0d accepted fetches, required at least 50", d, n_acc);
        end
    endtask

    task automatic test_reset_midflight(input int d);
        logic [31:0] wd;
        bit          acc;
        bit          pop;
        wd = $urandom | 32'h80000000;
        drive(d, 1'b0, 32'h0, 1'b1, 32'h40, wd, 1'b1);
        tick(d, acc, pop);
        drive(d, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1);
        tick(d, acc, pop);
        drive(d, 1'b1, 32'h44, 1'b0, 32'h0, 32'h0, 1'b1);
        tick(d, acc, pop);
        drive(d, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (rsp_valid[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight: dut%0d got rsp_valid=%b before reset, required 1", d, rsp_valid[d]);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid[d], init_done[d], fetch_ready[d], rsp_instr[d], rsp_addr[d]} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: dut%0d got vld=%b done=%b rdy=%b instr=%h addr=%h, required all zero",
                     d, rsp_valid[d], init_done[d], fetch_ready[d], rsp_instr[d], rsp_addr[d]);
        end
        exp_q.delete();
        test_reset();
        fetch_one(d, 32'h40);
        n_checks++;
        if (rsp_instr[d] !== NOP) begin
            n_fail++;
            $display("FAIL cleared_word: dut%0d got instr=%h, required %h", d, rsp_instr[d], NOP);
        end
        drain(d);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_idle_fetch(d);
            test_program(d);
            test_faults(d);
            test_back_to_back(d);
            test_prog_priority(d);
            test_random(d);
            test_reset_midflight(d);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
